// File: rtl/secret_chk.sv
// -----------------------------------------------------------------------------
// secret_chk
//   Hardware shadow stack for call/return integrity. It sits in decode, right
//   after the secure-jump filter.
//   - JAL/JALR push their return address (pc + 8, past the delay slot).
//   - JR $ra pops the top entry and compares it against the resolved $ra.
//   - A return that does not match is replaced by a NOP (32'h0) and flagged.
//   - Stack overflow and underflow are also treated as violations.
//
// Optional feature macro: SECRET_LOCK_EN
//   When defined, the first violation moves the block from RUN to LOCK.
//   In LOCK every valid instruction is suppressed and the stack is frozen.
//   The only way out of LOCK is rst.
//   When undefined, the block stays in RUN.
//   Only the offending instruction is suppressed.
//
// Ports
//   clk          in   1      rising-edge clock
//   rst          in   1      synchronous active-high reset (flushes the stack)
//   instr_vld_i  in   1      instr_i/pc_i/ra_i valid this cycle
//   instr_i      in   32     MIPS instruction from the secure-jump filter
//   pc_i         in   32     PC of instr_i
//   ra_i         in   32     resolved rs value (meaningful for JR)
//   instr_vld_o  out  1      registered copy of instr_vld_i
//   instr_o      out  32     instr_i, or 32'h0 when suppressed
//   viol_o       out  1      one-cycle pulse, aligned with the suppressed instr_o
//   viol_cnt_o   out  8      saturating violation count
//   depth_o      out  AW+1   current stack occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module secret_chk #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_vld_i,
  input  logic [31:0]   instr_i,
  input  logic [31:0]   pc_i,
  input  logic [31:0]   ra_i,
  output logic          instr_vld_o,
  output logic [31:0]   instr_o,
  output logic          viol_o,
  output logic [7:0]    viol_cnt_o,
  output logic [AW:0]   depth_o
);

  typedef enum logic {
    RUN  = 1'b0,
    LOCK = 1'b1
  } state_e;

  localparam logic [AW:0]   SP_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   SP_FULL = {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0] IDX_ONE = {{(AW-1){1'b0}}, 1'b1};

  state_e      state_q, state_d;
  logic [AW:0] sp_q, sp_d;
  logic        vld_q, vld_d;
  logic [31:0] instr_q, instr_d;
  logic        viol_q, viol_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] stack_q [DEPTH];

  logic          isCall, isRet, push, violation;
  logic [AW-1:0] topIdx;
  logic [31:0]   topVal;

  // JALR is SPECIAL funct 001001. JR counts as a return only when rs is $31.
  assign isCall = (instr_i[31:26] == 6'b000011) ||
                  ((instr_i[31:26] == 6'b000000) && (instr_i[5:0] == 6'b001001));
  assign isRet  = (instr_i[31:26] == 6'b000000) && (instr_i[5:0] == 6'b001000) &&
                  (instr_i[25:21] == 5'd31);

  // The pointer is one bit wider than the index, so full and empty stay
  // distinguishable. The low bits address the storage.
  assign topIdx = sp_q[AW-1:0] - IDX_ONE;
  assign topVal = stack_q[topIdx];

  // Next-state logic: classify the instruction, update the pointer and
  // decide whether to suppress it.
  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    vld_d     = instr_vld_i;
    instr_d   = 32'h0;
    viol_d    = 1'b0;
    cnt_d     = cnt_q;
    push      = 1'b0;
    violation = 1'b0;
    if (instr_vld_i && (state_q == RUN)) begin
      instr_d = instr_i;
      if (isCall) begin
        if (sp_q == SP_FULL) begin
          violation = 1'b1;
        end else begin
          push = 1'b1;
          sp_d = sp_q + SP_ONE;
        end
      end else if (isRet) begin
        if (sp_q == '0) begin
          violation = 1'b1;
        end else begin
          // A mismatched entry is still consumed.
          sp_d = sp_q - SP_ONE;
          if (ra_i != topVal) begin
            violation = 1'b1;
          end
        end
      end
      if (violation) begin
        instr_d = 32'h0;
        viol_d  = 1'b1;
        if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
`ifdef SECRET_LOCK_EN
        state_d = LOCK;
`endif
      end
    end
  end

  // State and output registers. Reset flushes the stack by clearing the
  // pointer and drops any instruction presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      sp_q    <= '0;
      vld_q   <= 1'b0;
      instr_q <= 32'h0;
      viol_q  <= 1'b0;
      cnt_q   <= 8'h0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      vld_q   <= vld_d;
      instr_q <= instr_d;
      viol_q  <= viol_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stack storage is not reset. The pointer alone defines which entries
  // are live. The return address wraps modulo 2^32.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      stack_q[sp_q[AW-1:0]] <= pc_i + 32'd8;
    end
  end

  assign instr_vld_o = vld_q;
  assign instr_o     = instr_q;
  assign viol_o      = viol_q;
  assign viol_cnt_o  = cnt_q;
  assign depth_o     = sp_q;

endmodule

// File: tb/tb_secret_chk.sv
// -----------------------------------------------------------------------------
// tb_secret_chk
//   Scoreboard bench for secret_chk.
//   The driver issues one input cycle per call to applyStimulus. A
//   queue-based shadow-stack model predicts the registered response, and the
//   prediction is pushed into a queue. An independent monitor pops one
//   expectation for each clock edge that consumed a stimulus. It compares the
//   prediction against the DUT outputs on the following falling edge.
//   Honours SECRET_LOCK_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_secret_chk;

  typedef struct {
    logic        vld;
    logic [31:0] instr;
    logic        viol;
    logic [7:0]  cnt;
    logic [4:0]  depth;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instrVld = 1'b0;
  logic [31:0] instr = 32'h0;
  logic [31:0] pc = 32'h0;
  logic [31:0] ra = 32'h0;
  logic        instrVldO;
  logic [31:0] instrO;
  logic        violO;
  logic [7:0]  violCntO;
  logic [4:0]  depthO;

  exp_t        expQ[$];
  int unsigned shadow[$];
  bit          locked = 1'b0;
  int          violCount = 0;
  int          checks = 0;
  int          errors = 0;

  secret_chk #(.DEPTH(16), .AW(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_vld_i (instrVld),
    .instr_i     (instr),
    .pc_i        (pc),
    .ra_i        (ra),
    .instr_vld_o (instrVldO),
    .instr_o     (instrO),
    .viol_o      (violO),
    .viol_cnt_o  (violCntO),
    .depth_o     (depthO)
  );

  always #5 clk = ~clk;

  // Compare one DUT output field against its prediction.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs and predict the outcome from the call/return rules.
  task automatic applyStimulus(input logic r, input logic v, input logic [31:0] ins,
                               input logic [31:0] p, input logic [31:0] a);
    exp_t e;
    bit   isCall, isRet, bad;
    @(posedge clk);
    #1;
    rst = r; instrVld = v; instr = ins; pc = p; ra = a;
    e.vld = 1'b0; e.instr = 32'h0; e.viol = 1'b0;
    if (r) begin
      shadow.delete();
      locked = 1'b0;
      violCount = 0;
    end else if (v) begin
      e.vld = 1'b1;
      if (!locked) begin
        isCall = (ins[31:26] == 6'd3) || (ins[31:26] == 6'd0 && ins[5:0] == 6'd9);
        isRet  = (ins[31:26] == 6'd0) && (ins[5:0] == 6'd8) && (ins[25:21] == 5'd31);
        bad = 1'b0;
        if (isCall) begin
          if (shadow.size() == 16) bad = 1'b1;
          else shadow.push_back(p + 32'd8);
        end else if (isRet) begin
          if (shadow.size() == 0) bad = 1'b1;
          else if (shadow.pop_back() != a) bad = 1'b1;
        end
        if (bad) begin
          e.viol = 1'b1;
          if (violCount < 255) violCount++;
`ifdef SECRET_LOCK_EN
          locked = 1'b1;
`endif
        end else begin
          e.instr = ins;
        end
      end
    end
    e.cnt   = 8'(violCount);
    e.depth = 5'(shadow.size());
    expQ.push_back(e);
  endtask

  function automatic logic [31:0] topOf();
    return (shadow.size() > 0) ? shadow[$] : 32'h0;
  endfunction

  // Monitor: one expectation per edge that consumed a stimulus.
  initial begin
    int   n;
    exp_t e;
    forever begin
      @(posedge clk);
      n = expQ.size();
      @(negedge clk);
      if (n > 0) begin
        e = expQ.pop_front();
        checkOutput("instr_vld_o", {31'b0, instrVldO}, {31'b0, e.vld});
        checkOutput("instr_o", instrO, e.instr);
        checkOutput("viol_o", {31'b0, violO}, {31'b0, e.viol});
        checkOutput("viol_cnt_o", {24'b0, violCntO}, {24'b0, e.cnt});
        checkOutput("depth_o", {27'b0, depthO}, {27'b0, e.depth});
      end
    end
  end

  localparam logic [31:0] JAL  = 32'h0C000010;
  localparam logic [31:0] JRRA = 32'h03E00008;
  localparam logic [31:0] ADDI = 32'h20210001;
  localparam logic [31:0] JR8  = 32'h01000008;

  initial begin
    logic [31:0] ins;
    int          sel;
    int          drain;
    $display("[TB] secret_chk scoreboard run starting");

    // Reset, then idle.
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0);

    // Balanced call and return.
    applyStimulus(0, 1, JAL, 32'h00400000, 0);
    applyStimulus(0, 1, JRRA, 32'h00400100, 32'h00400008);

    // Tampered return, then an ordinary instruction.
    applyStimulus(0, 1, JAL, 32'h00400000, 0);
    applyStimulus(0, 1, JRRA, 32'h00400100, 32'hDEADBEEF);
    applyStimulus(0, 1, ADDI, 32'h00400104, 0);
    applyStimulus(1, 0, 0, 0, 0);

    // Underflow.
    applyStimulus(0, 1, JRRA, 32'h00400200, 32'h00400008);
    applyStimulus(1, 0, 0, 0, 0);

    // Return-address wrap past 2^32.
    applyStimulus(0, 1, JAL, 32'hFFFFFFFC, 0);
    applyStimulus(0, 1, JRRA, 32'h00000010, 32'h00000004);

    // Fill to DEPTH, overflow once, then unwind in LIFO order.
    for (int i = 0; i < 17; i++) applyStimulus(0, 1, JAL, 32'h00410000 + 32'(i * 16), 0);
    for (int i = 15; i >= 0; i--)
      applyStimulus(0, 1, JRRA, 32'h00420000, 32'h00410008 + 32'(i * 16));
    applyStimulus(1, 0, 0, 0, 0);

    // Non-$ra JR and ADDI pass. Reset mid-stack drops the presented JAL.
    applyStimulus(0, 1, JAL, 32'h00400000, 0);
    applyStimulus(0, 1, JR8, 32'h00400004, 32'h12345678);
    applyStimulus(0, 1, ADDI, 32'h00400008, 0);
    applyStimulus(0, 1, JAL, 32'h00400010, 0);
    applyStimulus(1, 1, JAL, 32'h00400020, 0);
    applyStimulus(0, 0, 0, 0, 0);

    // Violation counter saturation.
    for (int i = 0; i < 260; i++) applyStimulus(0, 1, JRRA, 32'h00400000, 32'h0);
    applyStimulus(1, 0, 0, 0, 0);

    // Randomised mix of calls, returns and other instructions.
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2: ins = {6'b000011, 26'($urandom)};
        3:       ins = {6'b0, 5'($urandom), 5'b0, 5'($urandom), 5'b0, 6'b001001};
        4, 5, 6: ins = JRRA;
        7:       ins = {6'b0, 5'($urandom_range(0, 30)), 15'b0, 6'b001000};
        default: ins = $urandom;
      endcase
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0), ins,
                    $urandom, ($urandom_range(0, 3) != 0) ? topOf() : $urandom);
    end
    applyStimulus(0, 0, 0, 0, 0);

    // Let the monitor drain outstanding expectations, with a bound.
    drain = 0;
    while (expQ.size() > 0 && drain < 20) begin
      @(posedge clk);
      drain++;
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
